sram_addr_seq: RTL and testbench
================================

Name: sram_addr_seq

Overview:
- Upstream sequencer for the CPLD data-bus FSM that transfers bytes between the AVR and the SRAM.
- Accepts byte-wide commands from the AVR-side interface:
  - three address-byte loads, which build the SRAM address register;
  - data-access requests, which generate timed active-low we_n/oe_n strobes. These strobes drive the bus FSM's we/oe inputs and the SRAM.
- Holds the SRAM address stable for the whole access. Advances it after each access, so the AVR can stream bytes through the bus FSM.

Parameters:
- AWIDTH, 19, SRAM address width in bits; legal range 9..24.
- WAIT_CYCLES, 3, number of cycles the active strobe is held low; legal range 2..15.
  - The minimum of 2 is required because the bus FSM needs two strobe-low samples to buffer and then drive data.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  one-cycle command request, already synchronised to clk
- cmd_sel  in  2  command select:
  - 00: load address bits [7:0]
  - 01: load address bits [15:8]
  - 10: load address bits [23:16]
  - 11: data access
- cmd_rw  in  1  used for data access only; 0 = write (we_n), 1 = read (oe_n)
- cmd_byte  in  8  address byte for the load commands; ignored for data access
- cmd_ready  out  1  high when the block can accept a command (state IDLE)
- sram_addr  out  AWIDTH  current SRAM address
- we_n  out  1  write strobe, active low
- oe_n  out  1  read strobe, active low
- done  out  1  one-cycle pulse marking access completion
- ovr  out  1  sticky flag: a command arrived while cmd_ready was low

Behaviour:
- Reset values (applied at the next clk edge with reset=1, including mid-access):
  - state = IDLE, sram_addr = 0, we_n = 1, oe_n = 1, done = 0, ovr = 0;
  - the wait counter is cleared and any in-flight strobe is released immediately.
- All outputs are registered. cmd_ready = (state == IDLE).
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - cmd_valid with cmd_sel = 00, 01 or 10 writes cmd_byte into the addressed byte of the address register at that edge. The state stays IDLE and done is not pulsed.
  - Address bits at or above AWIDTH are discarded.
  - cmd_valid with cmd_sel = 11 latches cmd_rw and moves to SETUP.
- SETUP (1 cycle): both strobes high, address stable. Then move to STROBE.
- STROBE (WAIT_CYCLES cycles):
  - the selected strobe is low: we_n if cmd_rw = 0, oe_n if cmd_rw = 1; the other stays high;
  - the counter loads WAIT_CYCLES-1 on entry and counts down; at 0, move to HOLD.
- HOLD (1 cycle): both strobes high, address still stable, done = 1. Then return to IDLE.
- Address advance: on the HOLD->IDLE edge, sram_addr increments by 1, modulo 2^AWIDTH (all-ones wraps to 0).
- Latency, for a command sampled at edge 0:
  - SETUP during cycle 1;
  - strobe low during cycles 2..1+WAIT_CYCLES;
  - HOLD and done during cycle 2+WAIT_CYCLES;
  - cmd_ready and the incremented address during cycle 3+WAIT_CYCLES.
- Busy rules: cmd_valid while cmd_ready = 0 is dropped with no effect on state or address, and ovr is set. ovr clears only on reset.
- Invariant: we_n and oe_n are never low simultaneously; this holds in all states.
- Out-of-range cmd_rw/cmd_sel: X values need not be handled; all 2-bit cmd_sel codes are defined.

Optional Feature:
- Macro: SRAM_ADDR_AUTOINC_EN.
- Defined: sram_addr advances after each access as described above.
- Undefined: sram_addr changes only through address-load commands or reset; every access reuses the same address. Access timing, done and ovr are unchanged.

Test Plan:
- Reset, then idle 5 cycles:
  - sram_addr = 0, we_n = oe_n = 1, done = 0, ovr = 0, cmd_ready = 1.
- Load 0x34, 0x12, 0x05 via sel 00/01/10, AWIDTH = 19:
  - sram_addr = 0x51234, no strobes, cmd_ready stays 1.
- Write access at 0x51234, WAIT_CYCLES = 3:
  - we_n low for exactly cycles 2-4 after command, oe_n stays 1;
  - done in cycle 5;
  - address 0x51235 with cmd_ready = 1 in cycle 6 (autoinc build).
- Read access at address 0x7FFFF:
  - oe_n low for 3 cycles, we_n stays 1;
  - sram_addr wraps to 0x00000 afterwards.
- Command issued during STROBE:
  - ignored, ovr = 1 and stays 1;
  - original access timing and final address unchanged.
- Assert reset during STROBE of a read:
  - next edge gives oe_n = 1, state IDLE, sram_addr = 0, ovr = 0, no done pulse.

Source files
------------

// File: rtl/sram_addr_seq.sv
// Address/strobe sequencer in front of the SRAM bus FSM: builds the address from byte loads
// and times we_n/oe_n per access. Define SRAM_ADDR_AUTOINC_EN to advance the address after each access.
module sram_addr_seq #(
  parameter int AWIDTH      = 19,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_sel,
  input  logic              cmd_rw,
  input  logic [7:0]        cmd_byte,
  output logic              cmd_ready,
  output logic [AWIDTH-1:0] sram_addr,
  output logic              we_n,
  output logic              oe_n,
  output logic              done,
  output logic              ovr,
  output logic [1:0]        dbg_state
);

  // Handshake: a command is taken on any clk edge where cmd_valid && cmd_ready;
  // cmd_valid while cmd_ready is low is dropped and latches ovr.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] STROBE = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    we_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (cmd_valid & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_sel == 2'b11) begin
            rw_d    = cmd_rw;
            state_d = SETUP;
          end else begin
            // Bits of the selected byte lane that fall at or above AWIDTH are simply not stored.
            for (int i = 0; i < AWIDTH; i++) begin
              if ((i / 8) == int'(cmd_sel)) addr_d[i] = cmd_byte[i % 8];
            end
          end
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
        we_n_d  = rw_q;
        oe_n_d  = ~rw_q;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q - 4'd1;
          we_n_d = rw_q;
          oe_n_d = ~rw_q;
        end
      end
      HOLD: begin
        state_d = IDLE;
`ifdef SRAM_ADDR_AUTOINC_EN
        addr_d = addr_q + AWIDTH'(1);
`else
        addr_d = addr_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      we_n_q  <= we_n_d;
      oe_n_q  <= oe_n_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign sram_addr = addr_q;
  assign we_n      = we_n_q;
  assign oe_n      = oe_n_q;
  assign done      = done_q;
  assign ovr       = ovr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_addr_seq.sv
// Bench for sram_addr_seq: directed loads/accesses with per-cycle timing checks,
// plus a done-driven monitor that pops expected {rw, addr} entries from a queue.
module tb_sram_addr_seq;

  localparam int AW = 19;
  localparam int WC = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_sel = 2'b00;
  logic          cmd_rw = 1'b0;
  logic [7:0]    cmd_byte = 8'h00;
  logic          cmd_ready;
  logic [AW-1:0] sram_addr;
  logic          we_n;
  logic          oe_n;
  logic          done;
  logic          ovr;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic exp_ovr = 1'b0;
  logic [AW:0] exp_q[$];

  sram_addr_seq #(.AWIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_sel(cmd_sel),
    .cmd_rw(cmd_rw), .cmd_byte(cmd_byte), .cmd_ready(cmd_ready),
    .sram_addr(sram_addr), .we_n(we_n), .oe_n(oe_n), .done(done),
    .ovr(ovr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
`ifdef SRAM_ADDR_AUTOINC_EN
    return a + AW'(1);
`else
    return a;
`endif
  endfunction

  // Command is sampled at the edge following this call; returns just after that edge (cycle 1).
  task automatic issue(input logic [1:0] sel, input logic rw, input logic [7:0] b);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_sel = sel; cmd_rw = rw; cmd_byte = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] sel, input logic [7:0] b);
    issue(sel, 1'b0, b);
    @(negedge clk);
    chk("load_ready", cmd_ready, 1);
    chk("load_we_n", we_n, 1);
    chk("load_oe_n", oe_n, 1);
    chk("load_done", done, 0);
  endtask

  task automatic access(input logic rw, input int inject_at, input logic [AW-1:0] a);
    exp_q.push_back({rw, a});
    issue(2'b11, rw, 8'h00);
    for (int c = 1; c <= WC + 3; c++) begin
      @(negedge clk);
      chk("acc_ready", cmd_ready, (c == WC + 3));
      chk("acc_we_n", we_n, !(rw == 1'b0 && c >= 2 && c <= WC + 1));
      chk("acc_oe_n", oe_n, !(rw == 1'b1 && c >= 2 && c <= WC + 1));
      chk("acc_done", done, (c == WC + 2));
      chk("acc_addr", sram_addr, (c == WC + 3) ? next_addr(a) : a);
      if (inject_at != 0 && c > inject_at) exp_ovr = 1'b1;
      chk("acc_ovr", ovr, exp_ovr);
      if (inject_at != 0 && c == inject_at) begin
        cmd_valid = 1'b1; cmd_sel = 2'b00; cmd_byte = 8'hAA;
      end else if (inject_at != 0 && c == inject_at + 1) begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  int we_cnt = 0;
  int oe_cnt = 0;
  logic [AW:0] mon_e;

  always @(negedge clk) begin
    if (reset) begin
      we_cnt = 0;
      oe_cnt = 0;
    end else begin
      chk("mon_strobe_excl", {31'd0, we_n | oe_n}, 1);
      if (!we_n) we_cnt++;
      if (!oe_n) oe_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_unexpected_done: got done=1 required no pending access at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mon_rw", (oe_cnt != 0), mon_e[AW]);
          chk("mon_addr", sram_addr, mon_e[AW-1:0]);
          chk("mon_strobe_len", we_cnt + oe_cnt, WC);
        end
        we_cnt = 0;
        oe_cnt = 0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_addr", sram_addr, 0);
    chk("rst_we_n", we_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_done", done, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_state", dbg_state, 0);

    load(2'b00, 8'h34);
    load(2'b01, 8'h12);
    load(2'b10, 8'h05);
    chk("load_addr", sram_addr, 32'h51234);

    access(1'b0, 0, 19'h51234);

    // Upper bits of the third byte lie above AWIDTH and must be dropped.
    load(2'b00, 8'hFF);
    load(2'b01, 8'hFF);
    load(2'b10, 8'hFF);
    chk("load_addr_max", sram_addr, 32'h7FFFF);
    access(1'b1, 0, 19'h7FFFF);

    load(2'b00, 8'h00);
    load(2'b01, 8'h01);
    load(2'b10, 8'h00);
    chk("load_addr_ovr", sram_addr, 32'h00100);
    access(1'b0, 2, 19'h00100);

    // Reset during STROBE of a read.
    issue(2'b11, 1'b1, 8'h00);
    @(negedge clk);
    chk("rr_setup_oe_n", oe_n, 1);
    @(negedge clk);
    chk("rr_strobe_oe_n", oe_n, 0);
    chk("rr_ovr_sticky", ovr, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rr_oe_n", oe_n, 1);
    chk("rr_we_n", we_n, 1);
    chk("rr_ready", cmd_ready, 1);
    chk("rr_state", dbg_state, 0);
    chk("rr_addr", sram_addr, 0);
    chk("rr_ovr", ovr, 0);
    chk("rr_done", done, 0);
    reset = 1'b0;
    exp_ovr = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_no_done", done, 0);
      chk("rr_idle", cmd_ready, 1);
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
